// File: rtl/tmr_error_monitor.sv
// rtl/tmr_error_monitor.sv - TMR voter error monitor: event counter, sticky flags, alarm, snapshot port
module tmr_error_monitor #(
    parameter int NSRC      = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NSRC-1:0]      tmrErr,
    input  logic                 clrReq,
    input  logic [CNT_WIDTH-1:0] threshold,
    input  logic                 snapReq,
    input  logic                 snapAck,
    output logic [CNT_WIDTH-1:0] errCount,
    output logic [NSRC-1:0]      errSticky,
    output logic                 alarm,
    output logic                 snapValid,
    output logic [CNT_WIDTH-1:0] snapCount,
    output logic [NSRC-1:0]      snapSticky
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        WAIT  = 2'd2
    } snap_state_t;

    snap_state_t          state;
    logic [NSRC-1:0]      err_q;
    logic [NSRC-1:0]      rise;
    logic [CNT_WIDTH:0]   inc;
    logic [CNT_WIDTH:0]   sum;
    logic [CNT_WIDTH-1:0] count_base;
    logic [CNT_WIDTH-1:0] count_next;
    logic [NSRC-1:0]      sticky_next;

    assign rise = tmrErr & ~err_q & {NSRC{enable}};

    always_comb begin
        inc = '0;
        for (int i = 0; i < NSRC; i++) begin
            inc = inc + {{CNT_WIDTH{1'b0}}, rise[i]};
        end
    end

    // A clear restarts from zero but still keeps this cycle's events.
    assign count_base  = clrReq ? '0 : errCount;
    assign sum         = {1'b0, count_base} + inc;
    assign count_next  = sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    assign sticky_next = clrReq ? rise : (errSticky | rise);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q     <= '0;
            errCount  <= '0;
            errSticky <= '0;
            alarm     <= 1'b0;
        end else begin
            err_q     <= tmrErr;
            errCount  <= count_next;
            errSticky <= sticky_next;
            alarm     <= (threshold != '0) && (count_next >= threshold);
        end
    end

    // Snapshot handshake; the unused encoding behaves as IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            snapValid  <= 1'b0;
            snapCount  <= '0;
            snapSticky <= '0;
        end else begin
            case (state)
                VALID: begin
                    if (snapAck) begin
                        state     <= WAIT;
                        snapValid <= 1'b0;
                    end
                end
                WAIT: begin
                    snapValid <= 1'b0;
                    if (!snapReq) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    if (snapReq) begin
                        state      <= VALID;
                        snapValid  <= 1'b1;
                        snapCount  <= count_next;
                        snapSticky <= sticky_next;
                    end else begin
                        state     <= IDLE;
                        snapValid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmr_error_monitor.sv
// tb/tb_tmr_error_monitor.sv - directed self-checking bench for tmr_error_monitor
module tb_tmr_error_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  tmrErr;
    logic        clrReq;
    logic [15:0] threshold;
    logic        snapReq;
    logic        snapAck;
    logic [15:0] errCount;
    logic [7:0]  errSticky;
    logic        alarm;
    logic        snapValid;
    logic [15:0] snapCount;
    logic [7:0]  snapSticky;

    logic [3:0]  threshold_s;
    logic [3:0]  errCount_s;
    logic [7:0]  errSticky_s;
    logic        alarm_s;
    logic        snapValid_s;
    logic [3:0]  snapCount_s;
    logic [7:0]  snapSticky_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tmr_error_monitor #(.NSRC(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .tmrErr(tmrErr), .clrReq(clrReq),
        .threshold(threshold), .snapReq(snapReq), .snapAck(snapAck),
        .errCount(errCount), .errSticky(errSticky), .alarm(alarm),
        .snapValid(snapValid), .snapCount(snapCount), .snapSticky(snapSticky)
    );

    tmr_error_monitor #(.NSRC(8), .CNT_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst), .enable(enable), .tmrErr(tmrErr), .clrReq(clrReq),
        .threshold(threshold_s), .snapReq(snapReq), .snapAck(snapAck),
        .errCount(errCount_s), .errSticky(errSticky_s), .alarm(alarm_s),
        .snapValid(snapValid_s), .snapCount(snapCount_s), .snapSticky(snapSticky_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  pulse_seq [4] = '{8'h08, 8'h08, 8'h00, 8'h08};
    logic [15:0] pulse_exp [4] = '{16'd1, 16'd1, 16'd1, 16'd2};

    initial begin
        rst = 1'b1; enable = 1'b1; tmrErr = 8'h00; clrReq = 1'b0;
        threshold = 16'd0; threshold_s = 4'd0; snapReq = 1'b0; snapAck = 1'b0;
        #12;
        check("rst_count", errCount, 0);
        check("rst_sticky", errSticky, 0);
        check("rst_alarm", alarm, 0);
        check("rst_valid", snapValid, 0);
        check("rst_snapcount", snapCount, 0);
        step();
        rst = 1'b0;
        step();

        // single source pulse train: one count per rising edge
        for (int i = 0; i < 4; i++) begin
            tmrErr = pulse_seq[i];
            step();
            check($sformatf("pulse_count%0d", i), errCount, pulse_exp[i]);
        end
        check("pulse_sticky", errSticky, 8'h08);
        tmrErr = 8'h00;
        step();

        // all sources at once; the 4-bit instance saturates
        tmrErr = 8'hFF;
        step();
        check("all_count", errCount, 10);
        check("all_sticky", errSticky, 8'hFF);
        check("small_count_a", errCount_s, 10);
        tmrErr = 8'h00; step();
        tmrErr = 8'hFF; step();
        check("all_count2", errCount, 18);
        check("small_sat", errCount_s, 15);
        tmrErr = 8'h00; step();
        tmrErr = 8'hFF; step();
        check("small_sat_hold", errCount_s, 15);

        // clear coincident with new events
        tmrErr = 8'h00; clrReq = 1'b1; step();
        clrReq = 1'b0;
        check("clr_zero", errCount, 0);
        tmrErr = 8'h1F; step();
        tmrErr = 8'h00; step();
        check("pre_clr_count", errCount, 5);
        tmrErr = 8'h03; clrReq = 1'b1; step();
        clrReq = 1'b0;
        check("clr_evt_count", errCount, 2);
        check("clr_evt_sticky", errSticky, 8'h03);
        check("clr_evt_small", errCount_s, 2);

        // threshold alarm
        tmrErr = 8'h00; clrReq = 1'b1; threshold = 16'd3; step();
        clrReq = 1'b0;
        check("alarm_cleared", alarm, 0);
        tmrErr = 8'h01; step();
        check("alarm_at1", alarm, 0);
        tmrErr = 8'h00; step();
        tmrErr = 8'h01; step();
        check("alarm_at2", alarm, 0);
        tmrErr = 8'h00; step();
        tmrErr = 8'h01; step();
        check("alarm_count3", errCount, 3);
        check("alarm_on", alarm, 1);
        tmrErr = 8'h00; clrReq = 1'b1; step();
        clrReq = 1'b0;
        check("alarm_clr", alarm, 0);
        check("alarm_clr_count", errCount, 0);
        threshold = 16'd0;

        // snapshot handshake
        tmrErr = 8'h01; snapReq = 1'b1; step();
        check("snap_valid", snapValid, 1);
        check("snap_count", snapCount, 1);
        check("snap_sticky", snapSticky, 8'h01);
        tmrErr = 8'h00; step();
        tmrErr = 8'h01; clrReq = 1'b1; step();
        clrReq = 1'b0;
        check("snap_live", errCount, 1);
        check("snap_frozen", snapCount, 1);
        tmrErr = 8'h00; step();
        tmrErr = 8'h01; step();
        check("snap_live2", errCount, 2);
        snapAck = 1'b1; step();
        snapAck = 1'b0;
        check("snap_acked", snapValid, 0);
        step(); step();
        check("snap_held_req", snapValid, 0);
        snapReq = 1'b0; step();
        check("snap_idle", snapValid, 0);
        snapReq = 1'b1; step();
        check("snap2_valid", snapValid, 1);
        check("snap2_count", snapCount, 2);

        // enable low freezes detection; level already high at re-enable not counted
        enable = 1'b0; tmrErr = 8'h03; step();
        check("dis_count", errCount, 2);
        enable = 1'b1; step();
        check("reen_count", errCount, 2);

        // reset mid-handshake clears immediately
        rst = 1'b1;
        #2;
        check("mid_rst_count", errCount, 0);
        check("mid_rst_valid", snapValid, 0);
        check("mid_rst_snapcount", snapCount, 0);
        check("mid_rst_sticky", errSticky, 0);
        rst = 1'b0; snapReq = 1'b0;
        step();
        check("post_rst_count", errCount, 2);
        check("post_rst_valid", snapValid, 0);
        snapReq = 1'b1; step();
        check("post_rst_snap", snapValid, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
